// File: rtl/mattrans_seq_ctrl_pkg.sv
// ============================================================================
// Module : mattrans_pkg
// Brief  : Shared state encoding and index helpers for the transpose sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mattrans_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    XPOSE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Width of an element index/count for an n-by-n matrix (never zero).
  function automatic int cnt_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  function automatic int flat_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mattrans_seq_ctrl_if.sv
// ============================================================================
// Module : mattrans_stream_if
// Brief  : Element-serial valid/ready stream with end-of-matrix marker.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mattrans_stream_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

`default_nettype wire

// File: rtl/mattrans_seq_ctrl_xpose.sv
// ============================================================================
// Module : mat_xpose_comb
// Brief  : Combinational N x N transpose of a flat row-major element vector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mat_xpose_comb
  import mattrans_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int MATRIX_SIZE = 4
) (
  input  wire logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat_in,
  output logic      [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat_out
);

  localparam int N = MATRIX_SIZE;

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign mat_out[flat_idx(r, c, N)*DATA_WIDTH +: DATA_WIDTH] =
             mat_in [flat_idx(c, r, N)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mattrans_seq_ctrl.sv
// ============================================================================
// Module : mattrans_seq_ctrl
// Brief  : Load / transpose / drain sequencer around mat_xpose_comb.
//          Optional MATTRANS_SEQ_PINGPONG_EN adds a second load buffer so
//          loading overlaps draining.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mattrans_seq_ctrl
  import mattrans_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int BIN_POS     = 8,
  parameter int MATRIX_SIZE = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  mattrans_stream_if.slave  in_s,
  mattrans_stream_if.master out_s,
  output logic              busy,
  output logic              err
);

  localparam int N  = MATRIX_SIZE;
  localparam int NE = N * N;
  localparam int CW = cnt_width(N);
  localparam int VW = NE * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_IDX = CW'(NE - 1);
`ifdef MATTRANS_SEQ_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  // The binary point only travels with the data; reject impossible placements.
  if (BIN_POS < 0 || BIN_POS > DATA_WIDTH || N < 2) begin : g_bad_cfg
    $error("mattrans_seq_ctrl: invalid BIN_POS or MATRIX_SIZE");
  end

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   wcnt;
  logic [CW-1:0]   rcnt;
  logic [VW-1:0]   ld_buf [NBUF];
  logic [VW-1:0]   obuf;
  logic [VW-1:0]   xp_in;
  logic [VW-1:0]   xp_out;
  logic            wsel;
  logic            rsel;
  logic            in_hs;
  logic            out_hs;
  logic            ld_done;
  logic            dr_done;
  logic            xp_pend;
  logic            ld_room;

  assign in_hs   = in_s.valid & in_s.ready;
  assign out_hs  = out_s.valid & out_s.ready;
  assign ld_done = in_hs & (wcnt == LAST_IDX);
  assign dr_done = out_hs & (rcnt == LAST_IDX);
  assign xp_in   = ld_buf[rsel];
  assign busy    = (state != LOAD) || (wcnt != '0);

`ifdef MATTRANS_SEQ_PINGPONG_EN
  logic [1:0] full;

  // A matrix is pending if its buffer is already full or completes this cycle.
  assign xp_pend = full[rsel] | (ld_done & (wsel == rsel));
  assign ld_room = ~full[wsel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsel <= 1'b0;
      rsel <= 1'b0;
      full <= '0;
    end else begin
      if (ld_done) begin
        full[wsel] <= 1'b1;
        wsel       <= ~wsel;
      end
      if (state == XPOSE) begin
        full[rsel] <= 1'b0;
        rsel       <= ~rsel;
      end
    end
  end
`else
  assign wsel    = 1'b0;
  assign rsel    = 1'b0;
  assign xp_pend = ld_done;
  assign ld_room = 1'b1;
`endif

  mat_xpose_comb #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MATRIX_SIZE (MATRIX_SIZE)
  ) u_xpose (
    .mat_in  (xp_in),
    .mat_out (xp_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    in_s.ready   = 1'b0;
    out_s.valid  = 1'b0;
    out_s.data   = '0;
    out_s.last   = 1'b0;
    case (state)
      LOAD: begin
        in_s.ready = rst_n & ld_room;
        if (xp_pend) state_nxt = XPOSE;
      end
      XPOSE: begin
        state_nxt = DRAIN;
      end
      DRAIN: begin
`ifdef MATTRANS_SEQ_PINGPONG_EN
        in_s.ready = rst_n & ld_room;
`endif
        out_s.valid = 1'b1;
        out_s.data  = obuf[int'(rcnt)*DATA_WIDTH +: DATA_WIDTH];
        out_s.last  = (rcnt == LAST_IDX);
        if (dr_done) state_nxt = xp_pend ? XPOSE : LOAD;
      end
      default: begin
        state_nxt = LOAD;
      end
    endcase
  end

  // Sequencing follows wcnt only; in_last just feeds the framing check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      rcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (in_hs) begin
        wcnt <= ld_done ? '0 : wcnt + CW'(1);
        if (in_s.last != (wcnt == LAST_IDX)) err <= 1'b1;
      end
      if (state == XPOSE) begin
        rcnt <= '0;
      end else if (out_hs) begin
        rcnt <= dr_done ? '0 : rcnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs) ld_buf[wsel][int'(wcnt)*DATA_WIDTH +: DATA_WIDTH] <= in_s.data;
    if (state == XPOSE) obuf <= xp_out;
  end

endmodule

`default_nettype wire

// File: tb/tb_mattrans_seq_ctrl.sv
// ============================================================================
// Module : tb_mattrans_seq_ctrl
// Brief  : Directed bench for mattrans_seq_ctrl (N=2 and N=3, 8-bit elements).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mattrans_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tb_valid, tb_last, tb_ready;
  logic [7:0] tb_data;
  int         sel;
  int         vectors = 0;
  int         fails = 0;
  int         cyc = 0;
  int         first_cyc, last_cyc;
  logic [7:0] vin  [48];
  logic [7:0] vexp [48];
  bit         pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  logic       o_valid, o_last, o_in_ready, o_busy, o_err;
  logic [7:0] o_data;
  logic       busy2, err2, busy3, err3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mattrans_stream_if #(.DATA_WIDTH(8)) in2 ();
  mattrans_stream_if #(.DATA_WIDTH(8)) out2 ();
  mattrans_stream_if #(.DATA_WIDTH(8)) in3 ();
  mattrans_stream_if #(.DATA_WIDTH(8)) out3 ();

  assign in2.valid  = tb_valid && (sel == 0);
  assign in2.data   = tb_data;
  assign in2.last   = tb_last;
  assign out2.ready = tb_ready && (sel == 0);
  assign in3.valid  = tb_valid && (sel == 1);
  assign in3.data   = tb_data;
  assign in3.last   = tb_last;
  assign out3.ready = tb_ready && (sel == 1);

  mattrans_seq_ctrl #(.DATA_WIDTH(8), .BIN_POS(4), .MATRIX_SIZE(2)) u_dut2 (
    .clk (clk), .rst_n (rst_n), .in_s (in2), .out_s (out2), .busy (busy2), .err (err2)
  );

  mattrans_seq_ctrl #(.DATA_WIDTH(8), .BIN_POS(4), .MATRIX_SIZE(3)) u_dut3 (
    .clk (clk), .rst_n (rst_n), .in_s (in3), .out_s (out3), .busy (busy3), .err (err3)
  );

`ifdef MATTRANS_SEQ_PINGPONG_EN
  logic busy4, err4;
  mattrans_stream_if #(.DATA_WIDTH(8)) in4 ();
  mattrans_stream_if #(.DATA_WIDTH(8)) out4 ();
  assign in4.valid  = tb_valid && (sel == 2);
  assign in4.data   = tb_data;
  assign in4.last   = tb_last;
  assign out4.ready = tb_ready && (sel == 2);

  mattrans_seq_ctrl #(.DATA_WIDTH(8), .BIN_POS(4), .MATRIX_SIZE(4)) u_dut4 (
    .clk (clk), .rst_n (rst_n), .in_s (in4), .out_s (out4), .busy (busy4), .err (err4)
  );
`endif

  always_comb begin
    o_valid    = out2.valid;
    o_data     = out2.data;
    o_last     = out2.last;
    o_in_ready = in2.ready;
    o_busy     = busy2;
    o_err      = err2;
    if (sel == 1) begin
      o_valid    = out3.valid;
      o_data     = out3.data;
      o_last     = out3.last;
      o_in_ready = in3.ready;
      o_busy     = busy3;
      o_err      = err3;
    end
`ifdef MATTRANS_SEQ_PINGPONG_EN
    if (sel == 2) begin
      o_valid    = out4.valid;
      o_data     = out4.data;
      o_last     = out4.last;
      o_in_ready = in4.ready;
      o_busy     = busy4;
      o_err      = err4;
    end
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // bad_idx >= 0 puts in_last only on that element; otherwise on each matrix end.
  task automatic send(input int n, input int ne, input int bad_idx);
    for (int i = 0; i < n; i++) begin
      int t;
      bit hs;
      t  = 0;
      hs = 1'b0;
      tb_valid = 1'b1;
      tb_data  = vin[i];
      tb_last  = (bad_idx >= 0) ? (i == bad_idx) : ((i % ne) == ne - 1);
      while (!hs && t < 400) begin
        @(negedge clk);
        hs = o_in_ready;
        step();
        t++;
      end
      if (!hs) begin
        check("send_timeout", {31'b0, hs}, 32'd1);
        break;
      end
      if (i == 0) first_cyc = cyc;
    end
    tb_valid = 1'b0;
    tb_last  = 1'b0;
  endtask

  task automatic recv(input int ne, input int stop_after, input bit stall);
    int idx;
    int t;
    bit hs;
    idx = 0;
    t   = 0;
    while (idx < stop_after && t < 400) begin
      tb_ready = stall ? pat[t % 6] : 1'b1;
      @(negedge clk);
      hs = 1'b0;
      if (o_valid) begin
        check("out_data", {24'b0, o_data}, {24'b0, vexp[idx]});
        check("out_last", {31'b0, o_last}, {31'b0, ((idx % ne) == ne - 1)});
`ifndef MATTRANS_SEQ_PINGPONG_EN
        check("in_ready_drain", {31'b0, o_in_ready}, 32'd0);
`endif
        hs = tb_ready;
      end
      step();
      t++;
      if (hs) begin
        idx++;
        last_cyc = cyc;
      end
    end
    tb_ready = 1'b0;
    if (idx < stop_after) check("recv_timeout", idx, stop_after);
  endtask

  task automatic post_drain_checks();
    @(negedge clk);
    check("idle_out_valid", {31'b0, o_valid}, 32'd0);
    check("idle_busy", {31'b0, o_busy}, 32'd0);
    check("idle_in_ready", {31'b0, o_in_ready}, 32'd1);
    step();
  endtask

  task automatic set4(input logic [7:0] a, b, c, d);
    vin[0] = a; vin[1] = b; vin[2] = c; vin[3] = d;
    vexp[0] = a; vexp[1] = c; vexp[2] = b; vexp[3] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sel = 0; tb_valid = 0; tb_data = '0; tb_last = 0; tb_ready = 0; rst_n = 1'b0;
    #12;
    check("rst_in_ready", {31'b0, o_in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, o_valid}, 32'd0);
    check("rst_out_last", {31'b0, o_last}, 32'd0);
    check("rst_out_data", {24'b0, o_data}, 32'd0);
    check("rst_busy", {31'b0, o_busy}, 32'd0);
    check("rst_err", {31'b0, o_err}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", {31'b0, o_in_ready}, 32'd1);

    // Matrix 10,20,30,40 with free-flowing output, latency checked.
    set4(8'h10, 8'h20, 8'h30, 8'h40);
    send(4, 4, -1);
    @(negedge clk);
    check("lat_xpose_valid", {31'b0, o_valid}, 32'd0);
    check("lat_xpose_in_ready", {31'b0, o_in_ready}, 32'd0);
    check("lat_xpose_busy", {31'b0, o_busy}, 32'd1);
    step();
    @(negedge clk);
    check("lat_drain_valid", {31'b0, o_valid}, 32'd1);
    step();
    recv(4, 4, 1'b0);
    check("t1_err", {31'b0, o_err}, 32'd0);
    post_drain_checks();

    // Same matrix with a stalling consumer.
    send(4, 4, -1);
    step();
    step();
    recv(4, 4, 1'b1);
    post_drain_checks();

    // N=3 instance, values 1..9.
    sel = 1;
    for (int i = 0; i < 9; i++) vin[i] = 8'(i + 1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) vexp[r*3+c] = 8'(c*3 + r + 1);
    send(9, 9, -1);
    step();
    step();
    recv(9, 9, 1'b0);
    post_drain_checks();

    // Framing error: in_last on the second element.
    sel = 0;
    set4(8'h10, 8'h20, 8'h30, 8'h40);
    send(4, 4, 1);
    check("err_set", {31'b0, o_err}, 32'd1);
    step();
    step();
    recv(4, 4, 1'b0);
    check("err_sticky", {31'b0, o_err}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("err_cleared", {31'b0, o_err}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;

    // Reset during drain after two output handshakes.
    send(4, 4, -1);
    step();
    step();
    recv(4, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, o_valid}, 32'd0);
    check("mid_rst_busy", {31'b0, o_busy}, 32'd0);
    check("mid_rst_out_data", {24'b0, o_data}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    set4(8'hA1, 8'hA2, 8'hA3, 8'hA4);
    send(4, 4, -1);
    step();
    step();
    recv(4, 4, 1'b0);
    post_drain_checks();

`ifdef MATTRANS_SEQ_PINGPONG_EN
    // Three back-to-back 4x4 matrices, fully overlapped.
    sel = 2;
    for (int m = 0; m < 3; m++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          vin[m*16 + r*4 + c]  = 8'(m*16 + r*4 + c);
          vexp[m*16 + r*4 + c] = 8'(m*16 + c*4 + r);
        end
    fork
      send(48, 16, -1);
      recv(16, 48, 1'b0);
    join
    check("pp_cycles_ok", {31'b0, ((last_cyc - first_cyc + 1) <= 68)}, 32'd1);
    post_drain_checks();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
